// File: rtl/scsi_dma_fifo_pkg.sv
// scsi_dma_fifo_pkg: shared constants and lane helpers for the SCSI DMA FIFO.
//   DIR_*       : DMADIR encodings
//   LANE0..3    : byte-lane indices, big-endian (LANE0 = bits 31:24)
//   DEPTH_DEF   : default number of 32-bit entries
//   lane_get/put: extract / insert one byte lane of a longword
package scsi_dma_fifo_pkg;

  localparam logic DIR_SCSI2MEM = 1'b0;
  localparam logic DIR_MEM2SCSI = 1'b1;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  localparam int DEPTH_DEF = 8;

  function automatic logic [7:0] lane_get(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      LANE0:   b = word[31:24];
      LANE1:   b = word[23:16];
      LANE2:   b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] lane_put(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (lane)
      LANE0:   w[31:24] = b;
      LANE1:   w[23:16] = b;
      LANE2:   w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/scsi_dma_fifo_byte_ptr.sv
// fifo_byte_ptr: 2-bit byte-lane pointer.
//   clk, rst_n : clock, async active-low reset
//   load       : load {load_a1,0} (start alignment); highest priority
//   clr        : force to lane 0 (partial-entry flush)
//   inc        : advance one lane, wrapping 3->0
//   ptr        : current lane
//   wrap       : inc on lane 3 this cycle (entry boundary crossed)
module fifo_byte_ptr
  import scsi_dma_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       load_a1,
  input  logic       inc,
  input  logic       clr,
  output logic [1:0] ptr,
  output logic       wrap
);

  // wrap deliberately ignores clr so the top can use it to decide clr
  // without forming a combinational loop.
  assign wrap = inc & ~load & (ptr == LANE3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= LANE0;
    else if (load)  ptr <= {load_a1, 1'b0};
    else if (clr)   ptr <= LANE0;
    else if (inc)   ptr <= ptr + 2'd1;
  end

endmodule

// File: rtl/scsi_dma_fifo.sv
// scsi_dma_fifo: longword FIFO between the SCSI byte port and the host DMA.
//   DMADIR=0 packs BYTE_WR bytes big-endian into entries popped by LW_RD.
//   DMADIR=1 takes LW_WR longwords and unpacks them through BYTE_RD.
//   nCPUCLK/RST_      : clock, async active-low reset
//   DMAENA, DMADIR    : enable / direction from the register block
//   FLUSHFIFO         : commit a partial entry (SCSI->memory), STOPFLUSH when done
//   ACR_WR, A1        : address-counter write; rising edge restarts the FIFO
//   BYTE_* / LW_*     : byte-side and longword-side data strobes and data
//   FIFOEMPTY/FIFOFULL/OVERRUN/BYTE_READY/LW_READY : status
module scsi_dma_fifo
  import scsi_dma_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        nCPUCLK,
  input  logic        RST_,
  input  logic        DMAENA,
  input  logic        DMADIR,
  input  logic        FLUSHFIFO,
  input  logic        ACR_WR,
  input  logic        A1,
  input  logic        BYTE_WR,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_RD,
  output logic [7:0]  BYTE_OUT,
  input  logic        LW_WR,
  input  logic [31:0] LW_IN,
  input  logic        LW_RD,
  output logic [31:0] LW_OUT,
  output logic        BYTE_READY,
  output logic        LW_READY,
  output logic        FIFOEMPTY,
  output logic        FIFOFULL,
  output logic        STOPFLUSH,
  output logic        OVERRUN
);

  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          empty_q, full_q, overrun_q, stop_q, acr_q;
  logic          wfirst;      // next byte write starts a fresh entry
  logic [1:0]    wbp, rbp;
  logic          wbp_wrap, rbp_wrap;

  logic acr_edge, s2m, m2s;
  logic lw_pop, byte_step, pop, space;
  logic byte_wr_acc, flush_commit, lw_push, push, ovf;
  logic [31:0] head, wbase;

  assign acr_edge = ACR_WR & ~acr_q;
  // ACR restart pre-empts every strobe in its cycle
  assign s2m = DMAENA & (DMADIR == DIR_SCSI2MEM) & ~acr_edge;
  assign m2s = DMAENA & (DMADIR == DIR_MEM2SCSI) & ~acr_edge;

  assign lw_pop    = s2m & LW_RD & ~empty_q;
  assign byte_step = m2s & BYTE_RD & ~empty_q;
  assign pop       = lw_pop | rbp_wrap;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign space     = ~full_q | pop;

  assign byte_wr_acc  = s2m & BYTE_WR & space;
  assign flush_commit = ~acr_edge & (DMADIR == DIR_SCSI2MEM) & FLUSHFIFO &
                        (wbp != LANE0) & ~wbp_wrap & space;
  assign lw_push      = m2s & LW_WR & space;
  assign push         = wbp_wrap | flush_commit | lw_push;
  assign ovf          = ((s2m & BYTE_WR) | (m2s & LW_WR)) & ~space;

  fifo_byte_ptr u_wbp (
    .clk(nCPUCLK), .rst_n(RST_), .load(acr_edge), .load_a1(A1),
    .inc(byte_wr_acc), .clr(flush_commit), .ptr(wbp), .wrap(wbp_wrap)
  );

  fifo_byte_ptr u_rbp (
    .clk(nCPUCLK), .rst_n(RST_), .load(acr_edge), .load_a1(A1),
    .inc(byte_step), .clr(1'b0), .ptr(rbp), .wrap(rbp_wrap)
  );

  always_comb begin
    count_nxt = count;
    if (push & ~pop)      count_nxt = count + 1'b1;
    else if (pop & ~push) count_nxt = count - 1'b1;
  end

  // First byte of an entry zeroes every other lane, so lanes below the
  // start lane and lanes never written before a flush both read as 0.
  assign wbase = wfirst ? 32'h0 : mem[wptr];

  always_ff @(posedge nCPUCLK) begin
    if (byte_wr_acc)  mem[wptr] <= lane_put(wbase, wbp, BYTE_IN);
    else if (lw_push) mem[wptr] <= LW_IN;
  end

  always_ff @(posedge nCPUCLK or negedge RST_) begin
    if (!RST_) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      stop_q    <= 1'b0;
      acr_q     <= 1'b0;
      wfirst    <= 1'b1;
    end else begin
      acr_q  <= ACR_WR;
      stop_q <= FLUSHFIFO & empty_q & (wbp == LANE0);
      if (acr_edge) begin
        wptr      <= '0;
        rptr      <= '0;
        count     <= '0;
        empty_q   <= 1'b1;
        full_q    <= 1'b0;
        overrun_q <= 1'b0;
        wfirst    <= 1'b1;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        count   <= count_nxt;
        empty_q <= (count_nxt == '0);
        full_q  <= (count_nxt == CNT_FULL);
        if (ovf) overrun_q <= 1'b1;
        if (wbp_wrap | flush_commit) wfirst <= 1'b1;
        else if (byte_wr_acc)        wfirst <= 1'b0;
      end
    end
  end

  // Outputs are forced to 0 while empty so nothing uncommitted leaks out.
  assign head       = empty_q ? 32'h0 : mem[rptr];
  assign LW_OUT     = head;
  assign BYTE_OUT   = lane_get(head, rbp);
  assign FIFOEMPTY  = empty_q;
  assign FIFOFULL   = full_q;
  assign OVERRUN    = overrun_q;
  assign STOPFLUSH  = stop_q;
  assign LW_READY   = ~empty_q & (DMADIR == DIR_SCSI2MEM);
  assign BYTE_READY = ~empty_q & (DMADIR == DIR_MEM2SCSI);

endmodule

// File: tb/tb_scsi_dma_fifo.sv
module tb_scsi_dma_fifo;

  logic        nCPUCLK = 1'b0;
  logic        RST_ = 1'b0;
  logic        DMAENA = 1'b0, DMADIR = 1'b0, FLUSHFIFO = 1'b0;
  logic        ACR_WR = 1'b0, A1 = 1'b0;
  logic        BYTE_WR = 1'b0, BYTE_RD = 1'b0, LW_WR = 1'b0, LW_RD = 1'b0;
  logic [7:0]  BYTE_IN = '0, BYTE_OUT;
  logic [31:0] LW_IN = '0, LW_OUT;
  logic        BYTE_READY, LW_READY, FIFOEMPTY, FIFOFULL, STOPFLUSH, OVERRUN;

  scsi_dma_fifo #(.DEPTH(8), .AW(3)) dut (
    .nCPUCLK(nCPUCLK), .RST_(RST_), .DMAENA(DMAENA), .DMADIR(DMADIR),
    .FLUSHFIFO(FLUSHFIFO), .ACR_WR(ACR_WR), .A1(A1),
    .BYTE_WR(BYTE_WR), .BYTE_IN(BYTE_IN), .BYTE_RD(BYTE_RD), .BYTE_OUT(BYTE_OUT),
    .LW_WR(LW_WR), .LW_IN(LW_IN), .LW_RD(LW_RD), .LW_OUT(LW_OUT),
    .BYTE_READY(BYTE_READY), .LW_READY(LW_READY), .FIFOEMPTY(FIFOEMPTY),
    .FIFOFULL(FIFOFULL), .STOPFLUSH(STOPFLUSH), .OVERRUN(OVERRUN)
  );

  always #5 nCPUCLK = ~nCPUCLK;

  int passed = 0;
  int total  = 0;
  logic [31:0] lwq[$];
  logic [7:0]  bq[$];

  typedef struct {
    bit          acr;
    bit          a1;
    int          n;
    logic [31:0] bytes;
    bit          flush;
    logic [31:0] exp;
  } pk_t;
  pk_t tab[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge nCPUCLK);
    #1;
  endtask

  task automatic acr(input logic a1);
    A1 = a1; ACR_WR = 1'b1;
    tick();
    ACR_WR = 1'b0;
  endtask

  task automatic push_bytes(input logic [31:0] w);
    for (int k = 0; k < 4; k++) bq.push_back(w[31-8*k -: 8]);
  endtask

  task automatic lw_write(input logic [31:0] w, input bit queued);
    LW_IN = w; LW_WR = 1'b1;
    if (queued) push_bytes(w);
    tick();
    LW_WR = 1'b0;
  endtask

  task automatic byte_cmp(input string nm);
    logic [7:0] e;
    if (bq.size() == 0) check({nm, "_underflow"}, 32'd1, 32'd0);
    else begin
      e = bq.pop_front();
      check(nm, {24'h0, BYTE_OUT}, {24'h0, e});
    end
  endtask

  task automatic byte_read(input string nm);
    byte_cmp(nm);
    BYTE_RD = 1'b1;
    tick();
    BYTE_RD = 1'b0;
  endtask

  initial begin
    logic [31:0] e, bv;
    int guard;

    tab[0] = '{acr:1, a1:0, n:4, bytes:32'h11223344, flush:0, exp:32'h11223344};
    tab[1] = '{acr:1, a1:1, n:2, bytes:32'hAABB0000, flush:0, exp:32'h0000AABB};
    tab[2] = '{acr:0, a1:0, n:4, bytes:32'hC0FFEE11, flush:0, exp:32'hC0FFEE11};
    tab[3] = '{acr:1, a1:0, n:3, bytes:32'h01020300, flush:1, exp:32'h01020300};
    tab[4] = '{acr:1, a1:1, n:1, bytes:32'hCC000000, flush:1, exp:32'h0000CC00};
    tab[5] = '{acr:1, a1:0, n:1, bytes:32'h5A000000, flush:1, exp:32'h5A000000};

    // reset state
    #12;
    check("rst_empty", {31'h0, FIFOEMPTY}, 32'd1);
    check("rst_full", {31'h0, FIFOFULL}, 32'd0);
    check("rst_lwready", {31'h0, LW_READY}, 32'd0);
    check("rst_stopflush", {31'h0, STOPFLUSH}, 32'd0);
    check("rst_lwout", LW_OUT, 32'h0);
    check("rst_byteout", {24'h0, BYTE_OUT}, 32'h0);
    RST_ = 1'b1;
    DMAENA = 1'b1;
    tick();

    // SCSI->memory packing table
    DMADIR = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (tab[i].acr) acr(tab[i].a1);
      bv = tab[i].bytes;
      for (int j = 0; j < tab[i].n; j++) begin
        BYTE_IN = bv[31-8*j -: 8]; BYTE_WR = 1'b1;
        tick();
        BYTE_WR = 1'b0;
      end
      lwq.push_back(tab[i].exp);
      if (tab[i].flush) begin
        FLUSHFIFO = 1'b1;
        tick();
        check("flush_pending_stop", {31'h0, STOPFLUSH}, 32'd0);
      end
      check("pack_lwready", {31'h0, LW_READY}, 32'd1);
      check("pack_full", {31'h0, FIFOFULL}, 32'd0);
      e = lwq.pop_front();
      check("pack_lwout", LW_OUT, e);
      LW_RD = 1'b1;
      tick();
      LW_RD = 1'b0;
      check("pack_empty_after_rd", {31'h0, FIFOEMPTY}, 32'd1);
      if (tab[i].flush) begin
        tick();
        check("stopflush_set", {31'h0, STOPFLUSH}, 32'd1);
        FLUSHFIFO = 1'b0;
        tick();
        check("stopflush_clr", {31'h0, STOPFLUSH}, 32'd0);
      end
    end

    // memory->SCSI unpack
    acr(1'b0);
    DMADIR = 1'b1;
    lw_write(32'hDEADBEEF, 1);
    lw_write(32'h01234567, 1);
    check("unpack_byteready", {31'h0, BYTE_READY}, 32'd1);
    check("unpack_lwready", {31'h0, LW_READY}, 32'd0);
    for (int k = 0; k < 8; k++) byte_read("unpack_byte");
    check("unpack_empty", {31'h0, FIFOEMPTY}, 32'd1);
    check("unpack_byteready_off", {31'h0, BYTE_READY}, 32'd0);

    // full / overrun / simultaneous push+pop while full
    acr(1'b0);
    for (int k = 0; k < 8; k++) lw_write(32'h11111111 * (k + 1), 1);
    check("full_set", {31'h0, FIFOFULL}, 32'd1);
    check("full_no_ovr", {31'h0, OVERRUN}, 32'd0);
    for (int k = 0; k < 3; k++) byte_read("full_byte");
    byte_cmp("simul_byte");
    LW_IN = 32'h600DF00D; LW_WR = 1'b1; BYTE_RD = 1'b1;
    push_bytes(32'h600DF00D);
    tick();
    LW_WR = 1'b0; BYTE_RD = 1'b0;
    check("simul_full", {31'h0, FIFOFULL}, 32'd1);
    check("simul_no_ovr", {31'h0, OVERRUN}, 32'd0);
    lw_write(32'hBAD0BAD0, 0);
    check("ovr_set", {31'h0, OVERRUN}, 32'd1);
    check("ovr_full", {31'h0, FIFOFULL}, 32'd1);
    guard = 0;
    while (bq.size() > 0 && guard < 64) begin
      byte_read("drain_byte");
      guard++;
    end
    check("drain_bound", guard, 32);
    check("drain_empty", {31'h0, FIFOEMPTY}, 32'd1);
    check("ovr_sticky", {31'h0, OVERRUN}, 32'd1);

    // DMAENA=0 ignores strobes; ACR clears OVERRUN
    DMAENA = 1'b0;
    lw_write(32'h12345678, 0);
    check("dis_empty", {31'h0, FIFOEMPTY}, 32'd1);
    DMAENA = 1'b1;
    acr(1'b0);
    check("acr_ovr_clr", {31'h0, OVERRUN}, 32'd0);

    // reset mid-transfer
    DMADIR = 1'b0;
    BYTE_IN = 8'h12; BYTE_WR = 1'b1; tick();
    BYTE_IN = 8'h34; tick();
    BYTE_IN = 8'h56;
    #3 RST_ = 1'b0;
    #1;
    check("arst_empty", {31'h0, FIFOEMPTY}, 32'd1);
    check("arst_lwready", {31'h0, LW_READY}, 32'd0);
    check("arst_lwout", LW_OUT, 32'h0);
    BYTE_WR = 1'b0;
    tick();
    RST_ = 1'b1;
    tick();
    lwq.push_back(32'h89ABCDEF);
    bv = 32'h89ABCDEF;
    for (int j = 0; j < 4; j++) begin
      BYTE_IN = bv[31-8*j -: 8]; BYTE_WR = 1'b1;
      tick();
    end
    BYTE_WR = 1'b0;
    e = lwq.pop_front();
    check("post_rst_lwout", LW_OUT, e);
    check("post_rst_lwready", {31'h0, LW_READY}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/scsi_dma_fifo.md
Name: scsi_dma_fifo

Overview:
- Longword data FIFO between the SCSI byte port and the host-side 32-bit DMA engine.
- Packs bytes into big-endian longwords (SCSI→memory) or unpacks longwords into bytes (memory→SCSI).
- Direction, enable, flush and start alignment come from the register block.
- Returns FIFOEMPTY, FIFOFULL and STOPFLUSH to the register block.

Parameters:
- DEPTH, 8: number of 32-bit entries; power of two, minimum 2.
- AW, 3: entry pointer width; equals log2(DEPTH).

Ports:
- nCPUCLK  in  1  Sole clock; all state updates on its rising edge.
- RST_  in  1  Reset; asynchronous assert, active-low.
- DMAENA  in  1  DMA enabled; 0 ignores all data strobes.
- DMADIR  in  1  Direction; 1 = memory→SCSI, 0 = SCSI→memory.
- FLUSHFIFO  in  1  Flush request, level.
- ACR_WR  in  1  Address-counter write strobe, level, synchronous to nCPUCLK.
- A1  in  1  Start address bit 1 latched at the ACR write.
- BYTE_WR  in  1  SCSI byte push, one per cycle high; DMADIR=0.
- BYTE_IN  in  8  Byte pushed by BYTE_WR.
- BYTE_RD  in  1  SCSI byte pop; DMADIR=1.
- BYTE_OUT  out  8  Current head byte.
- LW_WR  in  1  Host longword push; DMADIR=1.
- LW_IN  in  32  Longword pushed by LW_WR.
- LW_RD  in  1  Host longword pop; DMADIR=0.
- LW_OUT  out  32  Head longword.
- BYTE_READY  out  1  A byte is available to the SCSI side.
- LW_READY  out  1  A longword is available to the host side.
- FIFOEMPTY  out  1  Zero committed entries.
- FIFOFULL  out  1  DEPTH committed entries.
- STOPFLUSH  out  1  Flush complete.
- OVERRUN  out  1  Sticky; a push was attempted while full.

Behaviour:
- Reset values:
  - Pointers, byte pointers, count, OVERRUN, STOPFLUSH, ACR_WR edge register: 0.
  - FIFOEMPTY=1, FIFOFULL=0, BYTE_READY=0, LW_READY=0, LW_OUT=0, BYTE_OUT=0.
  - Storage is not reset.
  - Reset mid-transfer discards all data.
- Storage and pointers:
  - DEPTH x 32 array; wptr/rptr are AW bits; count is AW+1 bits.
  - Pointers wrap DEPTH-1→0.
  - FIFOEMPTY = (count==0); FIFOFULL = (count==DEPTH); both are registered flags.
- Byte lanes: big-endian; byte pointer 0 = bits 31:24, 3 = bits 7:0.
- ACR_WR rising edge (detected against a registered copy), one-cycle latency:
  - wptr, rptr, count := 0; OVERRUN := 0.
  - Both byte pointers := {A1,0}.
  - Takes priority over any strobe in the same cycle.
- DMAENA=0: strobes are ignored; state is held, not cleared.
- Strobes for the non-active direction are ignored.
- SCSI→memory (DMADIR=0):
  - BYTE_WR writes BYTE_IN into lane wbp of entry wptr; wbp increments.
  - On the lane-3 write: wptr++, count++, and lanes below the start lane of that entry read as 0.
  - BYTE_WR while FIFOFULL: data dropped, OVERRUN := 1.
  - LW_RD while LW_READY: rptr++, count--. LW_RD while empty is ignored.
  - LW_OUT = entry[rptr], combinational from the array.
- Memory→SCSI (DMADIR=1):
  - LW_WR writes the entry at wptr, count++.
  - LW_WR while full: dropped, OVERRUN := 1.
  - BYTE_OUT = lane rbp of entry[rptr].
  - BYTE_RD increments rbp; on lane 3, rbp := 0, rptr++, count--.
  - BYTE_RD while empty is ignored.
- Simultaneous push and pop in one cycle:
  - count unchanged.
  - A pop and a push of the same entry while count==DEPTH is allowed: pop first, push accepted, no OVERRUN.
- Ready outputs:
  - LW_READY = !FIFOEMPTY & !DMADIR.
  - BYTE_READY = !FIFOEMPTY & DMADIR.
- Flush, SCSI→memory:
  - FLUSHFIFO high with wbp≠0: the next cycle commits the partial entry; unwritten lanes are 0; wptr++, count++, wbp := 0.
  - If full at that point, the commit waits until space exists.
  - A BYTE_WR in the commit cycle is applied first.
- Flush, memory→SCSI: no commit; the FIFO drains normally.
- STOPFLUSH:
  - Registered: STOPFLUSH := FLUSHFIFO & FIFOEMPTY & (wbp==0).
  - Falls one cycle after FLUSHFIFO drops.
  - Is 0 during any pending partial commit.

Decomposition:
- Shared package holds:
  - DIR_MEM2SCSI=1 and DIR_SCSI2MEM=0.
  - Lane index constants.
  - DEPTH default.
- One natural sub-module, fifo_byte_ptr: the 2-bit byte pointer with load-from-A1, increment, wrap strobe and flush clear; instantiated twice (write and read).
- The array and count stay in scsi_dma_fifo.

Test Plan:
- SCSI→memory pack: ACR_WR with A1=0, DMADIR=0, DMAENA=1; bytes 11,22,33,44 → LW_OUT=0x11223344, count=1, LW_READY=1; LW_RD → FIFOEMPTY=1.
- Odd-word start: ACR_WR with A1=1; bytes AA,BB → entry 0x0000AABB committed after 2 bytes; next 4 bytes form the full longword.
- Flush partial: bytes 01,02,03, then FLUSHFIFO=1 → LW_OUT=0x01020300 one cycle later; after LW_RD, STOPFLUSH=1; FLUSHFIFO=0 → STOPFLUSH=0 next cycle.
- Memory→SCSI unpack: DMADIR=1; LW_WR 0xDEADBEEF → BYTE_OUT sequence DE,AD,BE,EF over 4 BYTE_RD; FIFOEMPTY=1 after the 4th.
- Full/overrun: 8 LW_WR → FIFOFULL=1; 9th LW_WR → OVERRUN=1, count stays 8; simultaneous LW_WR + last-lane BYTE_RD while full → accepted, OVERRUN unchanged.
- Reset mid-transfer: RST_ low during a packed byte → all flags at reset values immediately, asynchronously; after release a new transfer starts clean.
